patient_priority_queue: RTL and testbench

PATIENT_PRIORITY_QUEUE -- requirements
Module: patient_priority_queue

---
 rtl/pq_pkg.sv | 12 +
 rtl/prio_fifo.sv | 48 ++++
 rtl/patient_priority_queue.sv | 84 ++++++++
 tb/tb_patient_priority_queue.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pq_pkg.sv
// pq_pkg: default sizing and patient record shared by the priority queue and its users
package pq_pkg;
    localparam int ID_W_DEF   = 2;
    localparam int PRIO_W_DEF = 2;
    localparam int DEPTH_DEF  = 4;
    localparam int CAP_DEF    = 15;

    typedef struct packed {
        logic [ID_W_DEF-1:0]   id;
        logic [PRIO_W_DEF-1:0] prio;
    } patient_t;
endpackage

// File: rtl/prio_fifo.sv
// prio_fifo: single priority level circular FIFO with show-ahead head and occupancy
module prio_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               din_i,
    output logic [W-1:0]               head_o,
    output logic [$clog2(DEPTH+1)-1:0] occ_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [OW-1:0] occ_q, occ_d;

    // pointers wrap naturally because DEPTH is a power of two; caller never pushes full or pops empty
    always_comb begin
        wr_d  = push_i ? wr_q + 1'b1 : wr_q;
        rd_d  = pop_i ? rd_q + 1'b1 : rd_q;
        occ_d = occ_q + OW'(push_i) - OW'(pop_i);
    end

    // pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            occ_q <= occ_d;
        end
    end

    // storage is not cleared on reset; occupancy alone marks valid entries
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= din_i;
    end

    assign head_o = mem_q[rd_q];
    assign occ_o  = occ_q;
endmodule

// File: rtl/patient_priority_queue.sv
// patient_priority_queue: strict-priority triage queue built from one FIFO per priority level
module patient_priority_queue
    import pq_pkg::*;
#(
    parameter int ID_W   = ID_W_DEF,
    parameter int PRIO_W = PRIO_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CAP    = CAP_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enq_valid,
    input  logic [ID_W-1:0]            enq_id,
    input  logic [PRIO_W-1:0]          enq_prio,
    output logic                       enq_ready,
    input  logic                       deq_ready,
    output logic                       deq_valid,
    output logic [ID_W-1:0]            deq_id,
    output logic [PRIO_W-1:0]          deq_prio,
    output logic [$clog2(CAP+1)-1:0]   count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow
);
    localparam int L  = 2**PRIO_W;
    localparam int CW = $clog2(CAP+1);
    localparam int OW = $clog2(DEPTH+1);

    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [OW-1:0]     occ [L];
    logic [ID_W-1:0]   head [L];
    logic [L-1:0]      push, pop;
    logic [PRIO_W-1:0] sel;
    logic              enq_fire, deq_fire;

    assign full      = count_q == CW'(CAP);
    assign empty     = count_q == '0;
    assign enq_ready = !full && occ[enq_prio] < OW'(DEPTH);
    assign deq_valid = !empty;
    assign enq_fire  = enq_valid && enq_ready;
    assign deq_fire  = deq_valid && deq_ready;
    assign deq_id    = deq_valid ? head[sel] : '0;
    assign deq_prio  = deq_valid ? sel : '0;
    assign count     = count_q;
    assign overflow  = overflow_q;

    // highest non-empty level wins; later iterations override lower levels
    always_comb begin
        sel = '0;
        for (int i = 0; i < L; i++) if (occ[i] != '0) sel = PRIO_W'(i);
    end

    for (genvar g = 0; g < L; g++) begin : g_lvl
        assign push[g] = enq_fire && enq_prio == PRIO_W'(g);
        assign pop[g]  = deq_fire && sel == PRIO_W'(g);
        prio_fifo #(.W(ID_W), .DEPTH(DEPTH)) u_fifo (
            .clk    (clk),
            .rst    (rst),
            .push_i (push[g]),
            .pop_i  (pop[g]),
            .din_i  (enq_id),
            .head_o (head[g]),
            .occ_o  (occ[g])
        );
    end

    // total occupancy tracks both handshakes; refused admissions raise a one-cycle flag
    always_comb begin
        count_d    = count_q + CW'(enq_fire) - CW'(deq_fire);
        overflow_d = enq_valid && !enq_ready;
    end

    // count and overflow registers
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end
endmodule

// File: tb/tb_patient_priority_queue.sv
// tb_patient_priority_queue: randomized and directed checks against a per-level queue model
module tb_patient_priority_queue;
    import pq_pkg::*;

    localparam int DEPTH = 4;
    localparam int CAP   = 15;
    localparam int L     = 4;

    logic       clk = 1'b0;
    logic       rst, enq_valid, deq_ready;
    logic [1:0] enq_id, enq_prio;
    logic       enq_ready, deq_valid, full, empty, overflow;
    logic [1:0] deq_id, deq_prio;
    logic [3:0] count;

    int checks = 0;
    int failures = 0;
    int mq [L][$];
    bit m_ovf = 1'b0;

    patient_t order_exp [3] = '{'{id: 2'd2, prio: 2'd3}, '{id: 2'd3, prio: 2'd1}, '{id: 2'd1, prio: 2'd0}};

    always #5 clk = ~clk;

    patient_priority_queue #(.ID_W(2), .PRIO_W(2), .DEPTH(DEPTH), .CAP(CAP)) dut (
        .clk(clk), .rst(rst), .enq_valid(enq_valid), .enq_id(enq_id), .enq_prio(enq_prio),
        .enq_ready(enq_ready), .deq_ready(deq_ready), .deq_valid(deq_valid), .deq_id(deq_id),
        .deq_prio(deq_prio), .count(count), .full(full), .empty(empty), .overflow(overflow)
    );

    function automatic int m_count();
        int s = 0;
        for (int p = 0; p < L; p++) s += mq[p].size();
        return s;
    endfunction

    function automatic int m_top();
        for (int p = L - 1; p >= 0; p--) if (mq[p].size() > 0) return p;
        return -1;
    endfunction

    function automatic bit m_ready();
        return m_count() < CAP && mq[enq_prio].size() < DEPTH;
    endfunction

    task automatic tick();
        int  t  = m_top();
        bit  ef = !rst && enq_valid && m_ready();
        bit  df = !rst && deq_ready && t >= 0;
        bit  ov = !rst && enq_valid && !m_ready();
        int  id = enq_id;
        int  pr = enq_prio;
        @(posedge clk);
        if (rst) begin
            for (int p = 0; p < L; p++) mq[p].delete();
            m_ovf = 1'b0;
        end else begin
            if (df) void'(mq[t].pop_front());
            if (ef) mq[pr].push_back(id);
            m_ovf = ov;
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit ev, input int id, input int pr, input bit dr);
        enq_valid = ev;
        enq_id    = 2'(id);
        enq_prio  = 2'(pr);
        deq_ready = dr;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({empty, full, deq_valid, enq_ready, deq_id, deq_prio, count, overflow} !== 14'b1001_00_00_0000_0) begin
            failures++;
            $display("FAIL reset_state got e=%b f=%b dv=%b er=%b id=%0d pr=%0d cnt=%0d ov=%b want e=1 f=0 dv=0 er=1 id=0 pr=0 cnt=0 ov=0",
                     empty, full, deq_valid, enq_ready, deq_id, deq_prio, count, overflow);
        end
    endtask

    task automatic test_order();
        do_reset();
        drive(1, 1, 0, 0);
        drive(1, 2, 3, 0);
        drive(1, 3, 1, 0);
        enq_valid = 1'b0;
        checks++;
        if (count !== 4'd3) begin failures++; $display("FAIL order_count got %0d want 3", count); end
        for (int k = 0; k < 3; k++) begin
            deq_ready = 1'b1;
            #1;
            checks++;
            if ({deq_valid, deq_id, deq_prio} !== {1'b1, order_exp[k].id, order_exp[k].prio}) begin
                failures++;
                $display("FAIL order_head%0d got v=%b id=%0d p=%0d want v=1 id=%0d p=%0d",
                         k, deq_valid, deq_id, deq_prio, order_exp[k].id, order_exp[k].prio);
            end
            tick();
        end
        deq_ready = 1'b0;
        checks++;
        if ({count, empty} !== {4'd0, 1'b1}) begin
            failures++;
            $display("FAIL order_drained got cnt=%0d e=%b want cnt=0 e=1", count, empty);
        end
    endtask

    task automatic test_level_full();
        do_reset();
        for (int k = 0; k < 4; k++) drive(1, k, 2, 0);
        enq_valid = 1'b1; enq_id = 2'd0; enq_prio = 2'd2;
        #1;
        checks++;
        if (enq_ready !== 1'b0) begin failures++; $display("FAIL level_full_ready got %b want 0", enq_ready); end
        tick();
        checks++;
        if ({overflow, count} !== {1'b1, 4'd4}) begin
            failures++;
            $display("FAIL level_full_overflow got ov=%b cnt=%0d want ov=1 cnt=4", overflow, count);
        end
        drive(0, 0, 0, 0);
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL overflow_pulse got %b want 0", overflow); end
        for (int k = 0; k < 4; k++) begin
            deq_ready = 1'b1;
            #1;
            checks++;
            if ({deq_id, deq_prio} !== {2'(k), 2'd2}) begin
                failures++;
                $display("FAIL level_fifo%0d got id=%0d p=%0d want id=%0d p=2", k, deq_id, deq_prio, k);
            end
            tick();
        end
        deq_ready = 1'b0;
    endtask

    task automatic test_full();
        do_reset();
        for (int p = 3; p >= 0; p--)
            for (int k = 0; k < (p == 0 ? 3 : 4); k++) drive(1, $urandom_range(0, 3), p, 0);
        enq_valid = 1'b1; enq_id = 2'd1; enq_prio = 2'd0; deq_ready = 1'b0;
        #1;
        checks++;
        if ({count, full, empty, enq_ready} !== {4'd15, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL full_state got cnt=%0d f=%b e=%b er=%b want cnt=15 f=1 e=0 er=0", count, full, empty, enq_ready);
        end
        tick();
        checks++;
        if ({overflow, count} !== {1'b1, 4'd15}) begin
            failures++;
            $display("FAIL full_overflow got ov=%b cnt=%0d want ov=1 cnt=15", overflow, count);
        end
        enq_valid = 1'b0;
        for (int k = 0; k < 15; k++) begin
            int t = m_top();
            deq_ready = 1'b1;
            #1;
            checks++;
            if ({deq_id, deq_prio} !== {2'(mq[t][0]), 2'(t)}) begin
                failures++;
                $display("FAIL full_drain%0d got id=%0d p=%0d want id=%0d p=%0d", k, deq_id, deq_prio, mq[t][0], t);
            end
            tick();
        end
        deq_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1, 0, 3, 0);
        drive(1, 1, 1, 0);
        enq_valid = 1'b1; enq_id = 2'd2; enq_prio = 2'd2; deq_ready = 1'b1;
        #1;
        checks++;
        if ({deq_id, deq_prio} !== {2'd0, 2'd3}) begin
            failures++;
            $display("FAIL b2b_head_before got id=%0d p=%0d want id=0 p=3", deq_id, deq_prio);
        end
        tick();
        enq_valid = 1'b0; deq_ready = 1'b0;
        #1;
        checks++;
        if ({count, deq_id, deq_prio} !== {4'd2, 2'd2, 2'd2}) begin
            failures++;
            $display("FAIL b2b_after got cnt=%0d id=%0d p=%0d want cnt=2 id=2 p=2", count, deq_id, deq_prio);
        end
    endtask

    task automatic test_reset_override();
        do_reset();
        for (int k = 0; k < 5; k++) drive(1, $urandom_range(0, 3), k % 4, 0);
        checks++;
        if (count !== 4'd5) begin failures++; $display("FAIL rst_ovr_pre got %0d want 5", count); end
        rst = 1'b1;
        drive(1, 3, 3, 1);
        rst = 1'b0;
        enq_valid = 1'b0; deq_ready = 1'b0;
        #1;
        checks++;
        if ({count, empty, deq_valid, overflow} !== {4'd0, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL rst_override got cnt=%0d e=%b dv=%b ov=%b want cnt=0 e=1 dv=0 ov=0", count, empty, deq_valid, overflow);
        end
    endtask

    task automatic test_empty_deq();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 1);
            checks++;
            if ({count, deq_valid, deq_id, deq_prio} !== 9'd0) begin
                failures++;
                $display("FAIL empty_deq%0d got cnt=%0d dv=%b id=%0d p=%0d want all 0", k, count, deq_valid, deq_id, deq_prio);
            end
        end
        deq_ready = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            int t, mc;
            bit ev;
            int eid, ep;
            bit hi_load = (c / 150) % 2 == 0;
            enq_valid = $urandom_range(0, 99) < (hi_load ? 80 : 30);
            enq_id    = 2'($urandom);
            enq_prio  = 2'($urandom);
            deq_ready = $urandom_range(0, 99) < (hi_load ? 25 : 75);
            #1;
            t   = m_top();
            mc  = m_count();
            ev  = t >= 0;
            eid = ev ? mq[t][0] : 0;
            ep  = ev ? t : 0;
            checks++;
            if ({deq_valid, deq_id, deq_prio, enq_ready, count, full, empty, overflow} !==
                {ev, 2'(eid), 2'(ep), m_ready(), 4'(mc), mc == CAP, mc == 0, m_ovf}) begin
                failures++;
                $display("FAIL random_c%0d got dv=%b id=%0d p=%0d er=%b cnt=%0d f=%b e=%b ov=%b want dv=%b id=%0d p=%0d er=%b cnt=%0d f=%b e=%b ov=%b",
                         c, deq_valid, deq_id, deq_prio, enq_ready, count, full, empty, overflow,
                         ev, eid, ep, m_ready(), mc, mc == CAP, mc == 0, m_ovf);
            end
            tick();
        end
        enq_valid = 1'b0; deq_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enq_valid = 1'b0; deq_ready = 1'b0; enq_id = '0; enq_prio = '0;
        @(negedge clk);
        test_reset();
        test_order();
        test_level_full();
        test_full();
        test_back_to_back();
        test_reset_override();
        test_empty_deq();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
